// File: rtl/bpu_pht_ctrl_pkg.sv
// bpu_pht_ctrl_pkg: shared PHT types, counter init value and saturating counter update
package bpu_pht_ctrl_pkg;
  localparam int PHT_IDX_W = 8;
  localparam int PHT_CNT_W = 2;
  typedef logic [PHT_CNT_W-1:0] pht_cnt_t;
  typedef struct packed {
    logic [PHT_IDX_W-1:0] idx;
    logic                 taken;
  } pht_upd_t;
  typedef enum logic {PHT_INIT, PHT_RUN} pht_state_e;
  localparam pht_cnt_t PHT_CNT_INIT = pht_cnt_t'((1 << (PHT_CNT_W - 1)) - 1);
  function automatic pht_cnt_t pht_sat_update(input pht_cnt_t c, input logic t);
    return t ? (&c ? c : c + pht_cnt_t'(1)) : (|c ? c - pht_cnt_t'(1) : c);
  endfunction
endpackage

// File: rtl/bpu_pht_ctrl_upd_fifo.sv
// bpu_pht_ctrl_upd_fifo: sync FIFO of pht_upd_t (clk, rst_n active-low sync, push/din, pop/dout, full, empty)
module bpu_pht_ctrl_upd_fifo
  import bpu_pht_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  pht_upd_t din,
  input  logic     pop,
  output pht_upd_t dout,
  output logic     full,
  output logic     empty
);
  localparam int PW = $clog2(DEPTH);
  logic [PW:0] wp, rp;
  pht_upd_t mem [DEPTH];
  assign empty = wp == rp;
  assign full = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
  assign dout = mem[rp[PW-1:0]];
  always_ff @(posedge clk)
    if (push) mem[wp[PW-1:0]] <= din;
  always_ff @(posedge clk)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + (PW+1)'(1);
      if (pop) rp <= rp + (PW+1)'(1);
    end
endmodule

// File: rtl/bpu_pht_ctrl.sv
// bpu_pht_ctrl: PHT SRAM controller (init walk, fetch lookups, buffered RMW updates); BPU_PHT_STATS_EN adds stat_upd_cnt/stat_stall_cnt
module bpu_pht_ctrl
  import bpu_pht_ctrl_pkg::*;
#(
  parameter int PHT_DEPTH      = 256,
  parameter int CNT_WIDTH      = PHT_CNT_W,
  parameter int PC_LSB         = 2,
  parameter int UPD_FIFO_DEPTH = 4,
  localparam int IDX_W         = $clog2(PHT_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fetch_valid,
  input  logic [31:0]          fetch_pc,
  output logic                 fetch_ready,
  output logic                 pred_valid,
  output logic                 pred_taken,
  input  logic                 update_valid,
  input  logic [31:0]          update_pc,
  input  logic                 update_taken,
  output logic                 update_ready,
  output logic                 init_done,
  output logic [IDX_W-1:0]     sram_r_addr,
  output logic [IDX_W-1:0]     sram_w_addr,
  output logic                 sram_wen,
  output logic [CNT_WIDTH-1:0] sram_data_in,
  input  logic [CNT_WIDTH-1:0] sram_data_out
`ifdef BPU_PHT_STATS_EN
  ,
  output logic [31:0]          stat_upd_cnt,
  output logic [31:0]          stat_stall_cnt
`endif
);
  pht_state_e state, state_nx;
  logic [IDX_W-1:0] walk_ptr, s1_idx;
  logic s1_fetch, s1_rmw, s1_taken;
  logic fifo_full, fifo_empty, push, pop, fetch_go, run, init, rmw_wr, unused_pc;
  pht_upd_t head, upd_ent;
  assign unused_pc = ^{fetch_pc, update_pc};
  // outputs are gated by rst_n so every output reads zero while reset is held
  assign run = rst_n && state == PHT_RUN;
  assign init = rst_n && state == PHT_INIT;
  assign rmw_wr = run && s1_rmw;
  assign fetch_go = run && fetch_valid && !fifo_full;
  assign pop = run && !fetch_go && !fifo_empty;
  assign push = run && update_valid && !fifo_full;
  assign upd_ent = '{idx: update_pc[PC_LSB +: IDX_W], taken: update_taken};
  bpu_pht_ctrl_upd_fifo #(.DEPTH(UPD_FIFO_DEPTH)) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .din  (upd_ent),
    .pop  (pop),
    .dout (head),
    .full (fifo_full),
    .empty(fifo_empty)
  );
  always_comb begin
    state_nx = state;
    if (state == PHT_INIT && walk_ptr == IDX_W'(PHT_DEPTH - 1)) state_nx = PHT_RUN;
  end
  // the SRAM is write-first, so an RMW write and the next read to the same index need no forwarding
  always_comb begin
    fetch_ready = fetch_go;
    update_ready = run && !fifo_full;
    init_done = run;
    pred_valid = run && s1_fetch;
    pred_taken = pred_valid && sram_data_out[CNT_WIDTH-1];
    sram_r_addr = fetch_go ? fetch_pc[PC_LSB +: IDX_W] : pop ? head.idx : '0;
    sram_wen = init || rmw_wr;
    sram_w_addr = init ? walk_ptr : rmw_wr ? s1_idx : '0;
    sram_data_in = init ? PHT_CNT_INIT : rmw_wr ? pht_sat_update(sram_data_out, s1_taken) : '0;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= PHT_INIT;
      walk_ptr <= '0;
      s1_fetch <= 1'b0;
      s1_rmw <= 1'b0;
      s1_idx <= '0;
      s1_taken <= 1'b0;
    end else begin
      state <= state_nx;
      walk_ptr <= state == PHT_INIT ? walk_ptr + IDX_W'(1) : '0;
      s1_fetch <= fetch_go;
      s1_rmw <= pop;
      s1_idx <= head.idx;
      s1_taken <= head.taken;
    end
`ifdef BPU_PHT_STATS_EN
  always_ff @(posedge clk)
    if (!rst_n) begin
      stat_upd_cnt <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (rmw_wr) stat_upd_cnt <= stat_upd_cnt + 32'd1;
      if (run && fetch_valid && !fetch_go) stat_stall_cnt <= stat_stall_cnt + 32'd1;
    end
`endif
endmodule
